// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and per-key event vector
// for the keyboard front end.
package ps2_codes_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] BAT_OK     = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic enter;
    logic left;
    logic right;
  } key_vec_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte stream from PS2_Controller into the decoder and decoded key levels/pulses
// out to the game FSM.
interface ps2_key_decoder_if;

  logic [7:0] received_data;
  logic       received_data_en;
  logic       EnterHeld;
  logic       LeftHeld;
  logic       RightHeld;
  logic       EnterPress;
  logic       LeftPress;
  logic       RightPress;
  logic       SeqError;

  modport master (
    output received_data, received_data_en,
    input  EnterHeld, LeftHeld, RightHeld,
    input  EnterPress, LeftPress, RightPress, SeqError
  );

  modport slave (
    input  received_data, received_data_en,
    output EnterHeld, LeftHeld, RightHeld,
    output EnterPress, LeftPress, RightPress, SeqError
  );

endinterface

// File: rtl/ps2_key_tracker.sv
// Per-key held level with typematic-repeat suppression: only the first make of a
// press produces a one-cycle pulse.
module ps2_key_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic i_make,
  input  logic i_brk,
  input  logic i_clr,
  output logic o_held,
  output logic o_press
);

  logic r_held;
  logic r_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= i_make & ~r_held & ~i_clr;
      if (i_clr || i_brk) begin
        r_held <= 1'b0;
      end else if (i_make) begin
        r_held <= 1'b1;
      end
    end
  end

  assign o_held  = r_held;
  assign o_press = r_press;

endmodule

// File: rtl/ps2_key_decoder.sv
// Make/break/extended-prefix decoder for Enter, Left and Right, with a timeout
// that abandons a prefix sequence whose next byte never arrives.
module ps2_key_decoder
  import ps2_codes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int CNT_W           = 20,
  parameter bit ACCEPT_KP_ENTER = 1'b1
) (
  input logic              CLOCK_50,
  input logic              Reset,
  ps2_key_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seq_error;
  logic             w_strobe;
  logic [7:0]       w_byte;
  logic             w_expire;
  logic             w_clr;
  key_vec_t         w_make;
  key_vec_t         w_brk;
  key_vec_t         w_held;
  key_vec_t         w_press;

  assign w_strobe = bus.received_data_en;
  assign w_byte   = bus.received_data;
  assign w_expire = !w_strobe && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (w_strobe) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_byte == PREFIX_EXT)      w_state_nxt = ST_EXT;
          else if (w_byte == PREFIX_BRK) w_state_nxt = ST_BRK;
        end
        ST_EXT: begin
          if (w_byte == PREFIX_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (w_byte != PREFIX_EXT) w_state_nxt = ST_IDLE;
        end
        ST_BRK, ST_EXT_BRK: w_state_nxt = ST_IDLE;
        default:            w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Key events are decoded from the byte that completes a sequence.
  always_comb begin
    w_make = '0;
    w_brk  = '0;
    w_clr  = 1'b0;
    if (w_strobe) begin
      unique case (r_state)
        ST_IDLE: begin
          w_make.enter = (w_byte == KEY_ENTER);
          w_clr        = (w_byte == BAT_OK);
        end
        ST_EXT: begin
          w_make.left  = (w_byte == KEY_LEFT);
          w_make.right = (w_byte == KEY_RIGHT);
          w_make.enter = (w_byte == KEY_ENTER) && ACCEPT_KP_ENTER;
        end
        ST_BRK: begin
          w_brk.enter = (w_byte == KEY_ENTER);
        end
        ST_EXT_BRK: begin
          w_brk.left  = (w_byte == KEY_LEFT);
          w_brk.right = (w_byte == KEY_RIGHT);
          w_brk.enter = (w_byte == KEY_ENTER) && ACCEPT_KP_ENTER;
        end
        default: ;
      endcase
    end
  end

  // Timeout counter: cleared by any byte, idle in IDLE, saturating otherwise.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      r_cnt       <= '0;
      r_seq_error <= 1'b0;
    end else begin
      r_seq_error <= w_expire;
      if (w_strobe || (r_state == ST_IDLE)) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  ps2_key_tracker u_enter (
    .clk     (CLOCK_50),
    .rst_n   (Reset),
    .i_make  (w_make.enter),
    .i_brk   (w_brk.enter),
    .i_clr   (w_clr),
    .o_held  (w_held.enter),
    .o_press (w_press.enter)
  );

  ps2_key_tracker u_left (
    .clk     (CLOCK_50),
    .rst_n   (Reset),
    .i_make  (w_make.left),
    .i_brk   (w_brk.left),
    .i_clr   (w_clr),
    .o_held  (w_held.left),
    .o_press (w_press.left)
  );

  ps2_key_tracker u_right (
    .clk     (CLOCK_50),
    .rst_n   (Reset),
    .i_make  (w_make.right),
    .i_brk   (w_brk.right),
    .i_clr   (w_clr),
    .o_held  (w_held.right),
    .o_press (w_press.right)
  );

  assign bus.EnterHeld  = w_held.enter;
  assign bus.LeftHeld   = w_held.left;
  assign bus.RightHeld  = w_held.right;
  assign bus.EnterPress = w_press.enter;
  assign bus.LeftPress  = w_press.left;
  assign bus.RightPress = w_press.right;
  assign bus.SeqError   = r_seq_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized byte streams against a prefix-queue reference model of
// the PS/2 make/break rules, with a short timeout.
module tb_ps2_key_decoder;

  localparam int T  = 16;
  localparam bit KP = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_seq_seen = 0;

  always #5 clk = ~clk;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES  (T),
    .CNT_W           (20),
    .ACCEPT_KP_ENTER (KP)
  ) u_dut (
    .CLOCK_50 (clk),
    .Reset    (rst_n),
    .bus      (bus)
  );

  // {EnterHeld, LeftHeld, RightHeld, EnterPress, LeftPress, RightPress, SeqError}
  logic [6:0] outs;
  assign outs = {bus.EnterHeld, bus.LeftHeld, bus.RightHeld,
                 bus.EnterPress, bus.LeftPress, bus.RightPress, bus.SeqError};

  // Reference model: bit 2 = Enter, 1 = Left, 0 = Right.
  logic [2:0] m_held;
  logic [2:0] m_press;
  logic       m_seq;
  logic [7:0] pend[$];
  int         m_idle;

  task automatic model_reset();
    m_held = '0; m_press = '0; m_seq = 1'b0; m_idle = 0;
    pend.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk;
    int key;
    m_idle = 0;
    if (pend.size() == 0 && (b == 8'hE0 || b == 8'hF0)) begin
      pend.push_back(b);
      return;
    end
    if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hE0) return;
    if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
      pend.push_back(b);
      return;
    end
    ext = 1'b0; brk = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hE0) ext = 1'b1;
      if (pend[i] == 8'hF0) brk = 1'b1;
    end
    pend.delete();
    key = -1;
    if (b == 8'h5A && (!ext || KP)) key = 2;
    else if (ext && b == 8'h6B)     key = 1;
    else if (ext && b == 8'h74)     key = 0;
    if (!ext && !brk && b == 8'hAA) m_held = '0;
    if (key >= 0) begin
      if (brk) m_held[key] = 1'b0;
      else if (!m_held[key]) begin
        m_held[key]  = 1'b1;
        m_press[key] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: present inputs, advance model at the edge, compare 1 ns later.
  task automatic step(input bit en, input logic [7:0] b, input string tag);
    bus.received_data_en = en;
    bus.received_data    = b;
    @(posedge clk);
    m_press = '0;
    m_seq   = 1'b0;
    if (en) begin
      model_byte(b);
    end else if (pend.size() != 0) begin
      m_idle++;
      if (m_idle == T) begin
        pend.delete();
        m_seq  = 1'b1;
        m_idle = 0;
      end
    end
    #1;
    check(tag, outs, {m_held, m_press, m_seq});
    if (outs[0]) n_seq_seen++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [10];
    int seq_before;

    pool = '{8'hE0, 8'hF0, 8'h5A, 8'h6B, 8'h74, 8'hAA, 8'hE1, 8'hFA, 8'hE0, 8'h6B};
    model_reset();
    bus.received_data_en = 1'b0;
    bus.received_data    = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs, 7'b0);
    rst_n = 1'b1;

    step(1, 8'h5A, "enter_make");
    step(0, 8'h5A, "enter_press_end");

    for (int i = 0; i < 3; i++) begin
      step(1, 8'hE0, "left_typematic_pfx");
      step(1, 8'h6B, "left_typematic");
    end
    step(1, 8'hE0, "left_break_e0");
    step(1, 8'hF0, "left_break_f0");
    step(1, 8'h6B, "left_break");

    step(1, 8'h6B, "keypad4");
    step(1, 8'h74, "keypad6");
    step(0, 8'h00, "keypad_idle");

    step(1, 8'hE0, "right_pfx");
    step(1, 8'h74, "right_make");
    step(1, 8'hE0, "left_pfx");
    step(1, 8'h6B, "both_held");
    step(1, 8'hE0, "right_break_e0");
    step(1, 8'hF0, "right_break_f0");
    step(1, 8'h74, "right_break");

    seq_before = n_seq_seen;
    step(1, 8'hE0, "timeout_pfx");
    for (int i = 0; i < T + 2; i++) step(0, 8'h6B, "timeout_wait");
    check("seqerr_once", 7'(n_seq_seen - seq_before), 7'd1);
    step(1, 8'h6B, "after_timeout_keypad");

    step(1, 8'h5A, "enter_repeat");
    step(1, 8'hAA, "bat_clear");

    step(1, 8'hE0, "pre_reset_pfx");
    step(1, 8'h6B, "pre_reset_left");
    step(1, 8'hE0, "ext_brk_e0");
    step(1, 8'hF0, "ext_brk_f0");
    bus.received_data_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", outs, 7'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'h6B, "post_reset_byte");

    for (int n = 0; n < 400; n++) begin
      int gap;
      gap = $urandom_range(0, 20);
      for (int g = 0; g < gap; g++) step(0, 8'($urandom), "rand_idle");
      step(1, pool[$urandom_range(0, 9)], "rand_byte");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sequences the raw PS/2 byte stream from PS2_Controller (received_data plus the one-cycle received_data_en strobe) through make/break/extended-prefix decoding.
- Produces clean held levels and single-cycle press pulses for the Enter, Left-arrow and Right-arrow keys.
- Sits between PS2_Controller and the game FSM, and is the only consumer of keyboard bytes.

Parameters:
TIMEOUT_CYCLES, 1_000_000, CLOCK_50 cycles a prefix state may wait for its next byte before abandoning the sequence (20 ms)
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES
ACCEPT_KP_ENTER, 1, 1 = keypad Enter (E0,5A) also counts as Enter; 0 = ignore it

Ports:
CLOCK_50  in  1  system clock, 50 MHz
Reset  in  1  asynchronous active-low reset; 0 clears all state
received_data  in  8  byte from PS2_Controller, valid only when received_data_en=1
received_data_en  in  1  one-cycle strobe per received byte
EnterHeld  out  1  level; 1 while Enter is down
LeftHeld  out  1  level; 1 while Left arrow is down
RightHeld  out  1  level; 1 while Right arrow is down
EnterPress  out  1  one-cycle pulse on the Enter make transition
LeftPress  out  1  one-cycle pulse on the Left make transition
RightPress  out  1  one-cycle pulse on the Right make transition
SeqError  out  1  one-cycle pulse when a prefix sequence is abandoned on timeout

Behaviour:
- Interface (already decided): one clock, CLOCK_50. Reset is asynchronous and active-low. Everything is sampled on the CLOCK_50 rising edge.
- Reset: all outputs 0, FSM in IDLE, counter 0. Reset asserted mid-sequence drops any partial sequence and any held state immediately.
- Bytes are acted on only in cycles where received_data_en=1. received_data is ignored otherwise.
- FSM states:
  - IDLE
  - EXT (seen E0)
  - BRK (seen F0)
  - EXT_BRK (seen E0,F0)
- FSM transitions on a strobe:
  - IDLE: E0->EXT; F0->BRK; 5A->make Enter, stay; AA (keyboard self-test pass)->clear all Held, stay; any other byte (E1, FA, FE, 6B, 74, ...)->ignored, stay.
  - EXT: F0->EXT_BRK; E0->stay EXT; 6B->make Left->IDLE; 74->make Right->IDLE; 5A->make Enter if ACCEPT_KP_ENTER else ignore ->IDLE; other->IDLE.
  - BRK: 5A->break Enter->IDLE; other->IDLE.
  - EXT_BRK: 6B->break Left; 74->break Right; 5A->break Enter if ACCEPT_KP_ENTER; all ->IDLE.
- 6B/74 without an E0 prefix are keypad 4/6 and never affect Left/Right.
- Make of key K:
  - If KHeld=0: KHeld<=1 and KPress pulses 1 cycle.
  - If KHeld=1 (typematic repeat): no pulse, no change.
- Break of key K: KHeld<=0. A break for a key not held is a no-op.
- Latency: Held and Press update on the clock edge after the strobe cycle (1 cycle). Press is high for exactly 1 cycle.
- Timeout:
  - The counter clears on every strobe and counts while the state is not IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no strobe: state<=IDLE, SeqError pulses 1 cycle, Held levels unchanged.
  - A strobe in the same cycle as expiry wins: the byte is decoded normally and there is no SeqError.
  - The counter saturates; it never wraps.
- Independent keys: Left and Right may both be held at once; each is tracked independently, with no priority.

Decomposition:
- Shared package ps2_codes_pkg holds the byte constants PREFIX_EXT=E0, PREFIX_BRK=F0, KEY_ENTER=5A, KEY_LEFT=6B, KEY_RIGHT=74, BAT_OK=AA, and the 2-bit state encoding.
- One natural sub-module, ps2_key_tracker, instantiated three times: inputs make, brk, clr; outputs Held, Press; holds the per-key edge/repeat-suppression logic.

Test Plan:
- Reset low for 3 cycles -> all outputs 0. Release, then strobe 5A -> next cycle EnterHeld=1 and EnterPress=1 for exactly 1 cycle.
- Strobe E0,6B,E0,6B,E0,6B (typematic) -> exactly one LeftPress pulse, LeftHeld=1. Then E0,F0,6B -> LeftHeld=0, no pulse.
- Strobe 6B alone, then 74 alone (keypad) -> LeftHeld, RightHeld, LeftPress and RightPress all stay 0.
- Strobe E0,74 then E0,6B -> RightHeld=1 and LeftHeld=1 together. Then E0,F0,74 -> RightHeld=0, LeftHeld=1.
- Strobe E0, then no strobe for TIMEOUT_CYCLES (test run with TIMEOUT_CYCLES=16) -> SeqError pulses once, FSM returns to IDLE. A following 6B does not set LeftHeld.
- Hold Enter (5A), then strobe AA -> EnterHeld=0. Separately, pull Reset low while in EXT_BRK -> all outputs 0 immediately, without waiting for a clock edge.
